// File: rtl/mc_datapath_gen.sv
// mc_datapath_gen: multicycle MIPS-32 datapath with register file, handshaked memory port and sub-word load/store lanes
module mc_datapath_gen #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_INC = 32'd4,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        RegWrite,
  input  logic        ALUSrcA,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        Branch,
  input  logic        BranchNe,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  RegDst,
  input  logic [1:0]  MemtoReg,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSource,
  input  logic [3:0]  ALU_operation,
  input  logic [2:0]  RAMCtrl,
  input  logic [31:0] data2CPU,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] M_addr,
  output logic [31:0] data_out,
  output logic [31:0] PC_Current,
  output logic [31:0] Inst,
  output logic        zero,
  output logic        overflow,
  output logic        busy,
  output logic        misalign
);
  localparam int RW = $clog2(NREGS);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rf_q [NREGS];
  logic [31:0] rf_d [NREGS];
  logic we_q, we_d, irw_q, irw_d, mis_q, mis_d;
  logic [3:0] be_q, be_d;
  logic [2:0] ctl_q, ctl_d;
  logic [4:0] rs, rt, wr_idx, sh;
  logic [31:0] rs_val, rt_val, imm, src_a, src_b, alu_res, add_r, sub_r, wr_val, pc_src;
  logic [31:0] req_addr, be_wdata, ld_val;
  logic [3:0] be_new;
  logic [15:0] lane_h;
  logic [7:0] lane_b;
  logic pc_we, wr_ok, start, bad, is_half;
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rs_val = 32'(rs) < NREGS ? rf_q[rs[RW-1:0]] : '0;
  assign rt_val = 32'(rt) < NREGS ? rf_q[rt[RW-1:0]] : '0;
  assign imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign src_a = ALUSrcA ? pc_q : a_q;
  assign src_b = ALUSrcB == 2'd0 ? b_q : ALUSrcB == 2'd1 ? PC_INC : ALUSrcB == 2'd2 ? imm : imm << 2;
  assign sh = src_b[4:0];
  assign add_r = src_a + src_b;
  assign sub_r = src_a - src_b;
  always_comb begin
    case (ALU_operation)
      4'b0000: alu_res = src_a & src_b;
      4'b0001: alu_res = src_a | src_b;
      4'b0010: alu_res = add_r;
      4'b0011: alu_res = src_a ^ src_b;
      4'b0100: alu_res = ~(src_a | src_b);
      4'b0101: alu_res = src_a >> sh;
      4'b0110: alu_res = sub_r;
      4'b0111: alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
      4'b1000: alu_res = {31'b0, src_a < src_b};
      4'b1001: alu_res = src_a << sh;
      4'b1010: alu_res = $signed(src_a) >>> sh;
      4'b1011: alu_res = src_b << 16;
      default: alu_res = '0;
    endcase
  end
  assign zero = alu_res == '0;
  assign overflow = ALU_operation == 4'b0010 ? (src_a[31] == src_b[31] && add_r[31] != src_a[31]) :
                    ALU_operation == 4'b0110 ? (src_a[31] != src_b[31] && sub_r[31] != src_a[31]) : 1'b0;
  assign busy = state_q == WAIT;
  assign pc_we = (PCWrite | (PCWriteCond & Branch & (zero ^ BranchNe))) & ~busy;
  assign pc_src = PCSource == 2'd0 ? alu_res : PCSource == 2'd1 ? alu_out_q :
                  PCSource == 2'd2 ? {pc_q[31:28], ir_q[25:0], 2'b00} : a_q;
  assign wr_idx = RegDst == 2'd0 ? rt : RegDst == 2'd1 ? ir_q[15:11] : RegDst == 2'd2 ? 5'd31 : 5'd0;
  assign wr_ok = RegWrite & ~busy & (wr_idx != 5'd0) & (32'(wr_idx) < NREGS);
  assign wr_val = MemtoReg == 2'd0 ? alu_out_q : MemtoReg == 2'd1 ? mdr_q : MemtoReg == 2'd2 ? pc_q : '0;
  assign start = ~busy & (MemRead | MemWrite);
  assign req_addr = IorD ? alu_out_q : pc_q;
  assign is_half = RAMCtrl == 3'd1 || RAMCtrl == 3'd2;
  assign bad = RAMCtrl > 3'd4 || (RAMCtrl == 3'd0 && req_addr[1:0] != 2'b00) || (is_half && req_addr[0]);
  assign be_new = RAMCtrl == 3'd0 ? 4'b1111 : is_half ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << req_addr[1:0];
  assign be_wdata = RAMCtrl == 3'd0 ? b_q : is_half ? {2{b_q[15:0]}} : {4{b_q[7:0]}};
  assign lane_h = addr_q[1] ? data2CPU[31:16] : data2CPU[15:0];
  assign lane_b = 8'(data2CPU >> {addr_q[1:0], 3'b000});
  assign ld_val = ctl_q == 3'd0 ? data2CPU : ctl_q == 3'd1 ? {{16{lane_h[15]}}, lane_h} :
                  ctl_q == 3'd2 ? {16'b0, lane_h} : ctl_q == 3'd3 ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
  always_comb begin
    pc_d = pc_we ? pc_src : pc_q;
    ir_d = ir_q;
    mdr_d = mdr_q;
    a_d = busy ? a_q : rs_val;
    b_d = busy ? b_q : rt_val;
    alu_out_d = alu_res;
    rf_d = rf_q;
    if (wr_ok) rf_d[wr_idx[RW-1:0]] = wr_val;
    state_d = state_q;
    addr_d = addr_q;
    we_d = we_q;
    irw_d = irw_q;
    be_d = be_q;
    ctl_d = ctl_q;
    wdata_d = wdata_q;
    mis_d = 1'b0;
    if (start && bad) mis_d = 1'b1;
    if (start && !bad) begin
      state_d = WAIT;
      addr_d = req_addr;
      we_d = MemWrite;
      irw_d = IRWrite & ~MemWrite;
      be_d = be_new;
      ctl_d = RAMCtrl;
      wdata_d = be_wdata;
    end
    if (busy && mem_ready) begin
      state_d = IDLE;
      mdr_d = we_q ? mdr_q : ld_val;
      ir_d = (!we_q && irw_q) ? data2CPU : ir_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q <= PC_RESET;
      ir_q <= '0;
      mdr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_out_q <= '0;
      rf_q <= '{default: '0};
      addr_q <= '0;
      we_q <= 1'b0;
      irw_q <= 1'b0;
      be_q <= '0;
      ctl_q <= '0;
      wdata_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      mdr_q <= mdr_d;
      a_q <= a_d;
      b_q <= b_d;
      alu_out_q <= alu_out_d;
      rf_q <= rf_d;
      addr_q <= addr_d;
      we_q <= we_d;
      irw_q <= irw_d;
      be_q <= be_d;
      ctl_q <= ctl_d;
      wdata_q <= wdata_d;
      mis_q <= mis_d;
    end
  end
  assign mem_req = busy;
  assign mem_we = we_q;
  assign mem_be = be_q;
  assign M_addr = addr_q;
  assign data_out = wdata_q;
  assign PC_Current = pc_q;
  assign Inst = ir_q;
  assign misalign = mis_q;
endmodule

// File: tb/tb_mc_datapath_gen.sv
// tb_mc_datapath_gen: directed table-driven bench for mc_datapath_gen (32- and 16-register builds)
module tb_mc_datapath_gen;
  logic clk, reset, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, BranchNe;
  logic MemRead, MemWrite, mem_ready;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [3:0] ALU_operation;
  logic [2:0] RAMCtrl;
  logic [31:0] data2CPU;
  logic mem_req, mem_we, zero, overflow, busy, misalign;
  logic [3:0] mem_be;
  logic [31:0] M_addr, data_out, PC_Current, Inst;
  logic mem_req_s, mem_we_s, zero_s, overflow_s, busy_s, misalign_s;
  logic [3:0] mem_be_s;
  logic [31:0] M_addr_s, data_out_s, PC_Current_s, Inst_s;
  int checks = 0;
  int failures = 0;
  logic [31:0] obs16;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] INST1 = 32'h0022_0800;
  localparam logic [31:0] INST2 = 32'h03FF_0000;
  localparam logic [31:0] INST3 = 32'h0014_0000;
  mc_datapath_gen #(.PC_RESET(RST_PC), .PC_INC(32'd4), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .BranchNe(BranchNe),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALU_operation(ALU_operation), .RAMCtrl(RAMCtrl), .data2CPU(data2CPU),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .M_addr(M_addr),
    .data_out(data_out), .PC_Current(PC_Current), .Inst(Inst), .zero(zero), .overflow(overflow),
    .busy(busy), .misalign(misalign));
  mc_datapath_gen #(.PC_RESET(RST_PC), .PC_INC(32'd4), .NREGS(16)) dut16 (
    .clk(clk), .reset(reset), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .BranchNe(BranchNe),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALU_operation(ALU_operation), .RAMCtrl(RAMCtrl), .data2CPU(data2CPU),
    .mem_ready(mem_ready), .mem_req(mem_req_s), .mem_we(mem_we_s), .mem_be(mem_be_s), .M_addr(M_addr_s),
    .data_out(data_out_s), .PC_Current(PC_Current_s), .Inst(Inst_s), .zero(zero_s), .overflow(overflow_s),
    .busy(busy_s), .misalign(misalign_s));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] op;
    logic [31:0] a, b, res;
    logic z, ov;
  } alu_vec_t;
  typedef struct {
    logic [2:0] ctl;
    logic [31:0] lo, data, exp;
    logic [3:0] be;
  } lane_vec_t;
  typedef struct {
    logic [31:0] a, b;
    logic ne;
    logic [31:0] pc;
  } br_vec_t;
  alu_vec_t av[14];
  lane_vec_t lv[5];
  br_vec_t bv[4];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic access(input logic w, input logic iord, input logic [2:0] ctl, input logic irw,
                        input logic [31:0] d, input int waits);
    MemWrite = w;
    MemRead = !w;
    IorD = iord;
    RAMCtrl = ctl;
    IRWrite = irw;
    step();
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    repeat (waits) step();
    data2CPU = d;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask
  task automatic wreg(input logic [1:0] dst, input logic [1:0] m2r);
    RegDst = dst;
    MemtoReg = m2r;
    RegWrite = 1'b1;
    step();
    RegWrite = 1'b0;
  endtask
  task automatic load_ab(input logic [31:0] a, input logic [31:0] b);
    access(1'b0, 1'b0, 3'd0, 1'b0, a, 0);
    wreg(2'b01, 2'b01);
    access(1'b0, 1'b0, 3'd0, 1'b0, b, 0);
    wreg(2'b00, 2'b01);
    step();
  endtask
  task automatic alu_obs(input string n, input logic [31:0] exp);
    step();
    MemRead = 1'b1;
    IorD = 1'b1;
    RAMCtrl = 3'd3;
    step();
    MemRead = 1'b0;
    chk(n, M_addr, exp);
    obs16 = M_addr_s;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
  endtask
  task automatic observe_mdr(input string n, input logic [31:0] exp);
    wreg(2'b01, 2'b01);
    wreg(2'b00, 2'b01);
    step();
    ALU_operation = 4'b0001;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'd0;
    alu_obs(n, exp);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    av[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    av[1]  = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    av[2]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    av[3]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    av[4]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    av[5]  = '{4'b1010, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0};
    av[6]  = '{4'b0101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0};
    av[7]  = '{4'b1001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0};
    av[8]  = '{4'b1011, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0};
    av[9]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    av[10] = '{4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1'b0};
    av[11] = '{4'b0011, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1'b0, 1'b0};
    av[12] = '{4'b0100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    av[13] = '{4'b1100, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0};
    lv[0] = '{3'd3, 32'd3, 32'h8012_3456, 32'hFFFF_FF80, 4'b1000};
    lv[1] = '{3'd4, 32'd3, 32'h8012_3456, 32'h0000_0080, 4'b1000};
    lv[2] = '{3'd2, 32'd2, 32'hBEEF_1234, 32'h0000_BEEF, 4'b1100};
    lv[3] = '{3'd1, 32'd2, 32'hBEEF_1234, 32'hFFFF_BEEF, 4'b1100};
    lv[4] = '{3'd0, 32'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111};
    bv[0] = '{32'd5, 32'd5, 1'b1, RST_PC};
    bv[1] = '{32'd5, 32'd5, 1'b0, 32'h0000_0000};
    bv[2] = '{32'd5, 32'd6, 1'b0, 32'h0000_0000};
    bv[3] = '{32'd5, 32'd6, 1'b1, 32'hFFFF_FFFF};
    {IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, BranchNe, MemRead, MemWrite, mem_ready} = '0;
    {RegDst, MemtoReg, ALUSrcB, PCSource} = '0;
    ALU_operation = 4'b0010;
    RAMCtrl = 3'd0;
    data2CPU = '0;
    reset = 1'b0;
    step();
    step();
    chk("rst_pc", PC_Current, RST_PC);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_ir", Inst, 0);
    reset = 1'b1;
    IorD = 1'b0;
    IRWrite = 1'b1;
    MemRead = 1'b1;
    step();
    MemRead = 1'b0;
    IRWrite = 1'b0;
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", M_addr, RST_PC);
    chk("fetch_be", mem_be, 4'b1111);
    PCWrite = 1'b1;
    PCSource = 2'd0;
    ALUSrcA = 1'b1;
    ALUSrcB = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fetch_wait%0d_pc", i), PC_Current, RST_PC);
      chk($sformatf("fetch_wait%0d_busy", i), busy, 1);
    end
    data2CPU = INST1;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    PCWrite = 1'b0;
    chk("fetch_ir", Inst, INST1);
    chk("fetch_done_req", mem_req, 0);
    chk("fetch_done_pc", PC_Current, RST_PC);
    ALUSrcA = 1'b0;
    ALUSrcB = 2'd0;
    ALU_operation = 4'b0010;
    step();
    chk("regs_zero", zero, 1);
    for (int i = 0; i < 14; i++) begin
      load_ab(av[i].a, av[i].b);
      ALU_operation = av[i].op;
      ALUSrcA = 1'b0;
      ALUSrcB = 2'd0;
      #1;
      chk($sformatf("alu%0d_zero", i), zero, av[i].z);
      chk($sformatf("alu%0d_ovf", i), overflow, av[i].ov);
      alu_obs($sformatf("alu%0d_res", i), av[i].res);
    end
    for (int i = 0; i < 5; i++) begin
      load_ab(32'h100, lv[i].lo);
      ALU_operation = 4'b0010;
      ALUSrcA = 1'b0;
      ALUSrcB = 2'd0;
      step();
      MemRead = 1'b1;
      IorD = 1'b1;
      RAMCtrl = lv[i].ctl;
      step();
      MemRead = 1'b0;
      chk($sformatf("lane%0d_addr", i), M_addr, 32'h100 + lv[i].lo);
      chk($sformatf("lane%0d_be", i), mem_be, lv[i].be);
      data2CPU = lv[i].data;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      observe_mdr($sformatf("lane%0d_mdr", i), lv[i].exp);
    end
    load_ab(32'hFFFF_F901, 32'h0000_00AB);
    ALU_operation = 4'b0010;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'd2;
    step();
    MemWrite = 1'b1;
    IorD = 1'b1;
    RAMCtrl = 3'd3;
    step();
    MemWrite = 1'b0;
    chk("sb_req", mem_req, 1);
    chk("sb_we", mem_we, 1);
    chk("sb_be", mem_be, 4'b0010);
    chk("sb_data", data_out, 32'hABAB_ABAB);
    chk("sb_addr", M_addr, 32'h0000_0101);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("sb_done", mem_req, 0);
    load_ab(32'hFFFF_F902, 32'h1234_5678);
    ALUSrcB = 2'd2;
    step();
    MemWrite = 1'b1;
    IorD = 1'b1;
    RAMCtrl = 3'd0;
    step();
    MemWrite = 1'b0;
    chk("sw_mis_pulse", misalign, 1);
    chk("sw_mis_noreq", mem_req, 0);
    step();
    chk("sw_mis_end", misalign, 0);
    chk("sw_mis_idle", mem_req, 0);
    for (int i = 0; i < 4; i++) begin
      load_ab(bv[i].a, bv[i].b);
      ALU_operation = 4'b0110;
      ALUSrcA = 1'b0;
      ALUSrcB = 2'd0;
      PCSource = 2'd1;
      step();
      BranchNe = bv[i].ne;
      PCWriteCond = 1'b1;
      Branch = 1'b1;
      step();
      PCWriteCond = 1'b0;
      Branch = 1'b0;
      chk($sformatf("br%0d_pc", i), PC_Current, bv[i].pc);
    end
    PCSource = 2'd2;
    PCWrite = 1'b1;
    step();
    PCWrite = 1'b0;
    chk("jump_pc", PC_Current, 32'hF088_2000);
    access(1'b0, 1'b0, 3'd0, 1'b1, INST2, 1);
    chk("fetch2_ir", Inst, INST2);
    wreg(2'b10, 2'b10);
    step();
    ALU_operation = 4'b0001;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'd0;
    alu_obs("jal_r31", 32'hF088_2000);
    chk("jal_r31_n16", obs16, 0);
    access(1'b0, 1'b0, 3'd0, 1'b1, INST3, 0);
    chk("fetch3_ir", Inst, INST3);
    wreg(2'b11, 2'b10);
    wreg(2'b00, 2'b10);
    step();
    ALU_operation = 4'b0000;
    alu_obs("r0_reads_zero", 32'h0);
    ALU_operation = 4'b0010;
    #1;
    chk("r20_n16_zero", zero_s, 1);
    alu_obs("r20_write", 32'hF088_2000);
    chk("r20_n16_dropped", obs16, 0);
    MemRead = 1'b1;
    IorD = 1'b0;
    IRWrite = 1'b1;
    step();
    MemRead = 1'b0;
    IRWrite = 1'b0;
    chk("rstwait_req", mem_req, 1);
    reset = 1'b0;
    data2CPU = 32'h1111_1111;
    mem_ready = 1'b1;
    step();
    reset = 1'b1;
    mem_ready = 1'b0;
    chk("rstwait_drop", mem_req, 0);
    chk("rstwait_ir", Inst, 0);
    chk("rstwait_pc", PC_Current, RST_PC);
    step();
    chk("rstwait_idle", mem_req, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_datapath_gen.md
# mc_datapath_gen

Parametrised multicycle MIPS-32 datapath with an internal register file, A/B operand latches, a request/ready memory handshake with stall, byte/halfword load-store lane handling and both BEQ/BNE branch conditions. It sits between the multicycle controller and the memory/IO bus. It replaces a datapath that assumed single-cycle memory, word-only access and a hard-coded PC increment.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- PC_INC, 4, constant on ALUSrcB=01 (PC increment)
- NREGS, 32, implemented registers (16 or 32); index ≥ NREGS reads 0, writes are dropped
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  in  1 each  controller strobes, same meaning as the previous datapath
- BranchNe  in  1  0: taken when zero=1 (BEQ); 1: taken when zero=0 (BNE)
- MemRead, MemWrite  in  1  one-cycle strobes starting a memory access
- RegDst, MemtoReg, ALUSrcB, PCSource  in  2 each  mux selects
- ALU_operation  in  4  ALU op
- RAMCtrl  in  3  access size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
- data2CPU  in  32  read data from memory
- mem_ready  in  1  memory completes the access in this cycle
- mem_req  out  1  access outstanding
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables, little-endian lanes
- M_addr  out  32  access address (held while mem_req)
- data_out  out  32  store data, lane-shifted
- PC_Current, Inst  out  32  PC and IR
- zero, overflow  out  1  ALU flags (combinational)
- busy  out  1  equals mem_req; controller holds its state while high
- misalign  out  1  one-cycle pulse: access rejected

## Operation
- Registers: PC, IR, MDR, A, B, ALUOut, regfile ($0 reads 0), handshake FSM IDLE/WAIT.
- A/B load rdata from Inst[25:21]/[20:16] every cycle that busy=0. ALUOut loads every cycle.
- ALUSrcA: 0 A, 1 PC. ALUSrcB: 00 B, 01 PC_INC, 10 sext imm, 11 sext imm<<2.
- ALU: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SRL, 0110 SUB, 0111 SLT signed, 1000 SLTU, 1001 SLL, 1010 SRA, 1011 LUI (B<<16), others 0. Shift amount B[4:0] shifts A. overflow only for ADD/SUB signed overflow, else 0. zero = (res==0).
- RegDst: 00 rt, 01 rd, 10 $31, 11 $0. MemtoReg: 00 ALUOut, 01 MDR, 10 PC_Current, 11 0.
- PCSource: 00 ALU result, 01 ALUOut, 10 {PC[31:28],Inst[25:0],2'b00}, 11 A (JR).
- PC write enable = (PCWrite | PCWriteCond & Branch & (zero ^ BranchNe)) & ~busy. RegWrite is gated by ~busy.
- FSM IDLE: on MemRead|MemWrite (write wins if both), addr = IorD ? ALUOut : PC.
  - Misaligned access (word with addr[1:0]≠0, half with addr[0]=1, or RAMCtrl>100): misalign=1 next cycle, stay IDLE.
  - Otherwise latch addr, we, RAMCtrl, lane-shifted B (byte replicated ×4, half ×2) and be (word 1111, half 0011/1100, byte one-hot by addr[1:0]); go WAIT.
- FSM WAIT: mem_req=1, outputs stable. On mem_ready:
  - For a read, MDR is loaded with the selected lane, sign/zero-extended, and IR loads raw data2CPU if IRWrite was high at the request.
  - FSM returns to IDLE. Strobes arriving during WAIT are ignored.

## Timing
- Reset (reset=0 at edge): PC=PC_RESET. IR, MDR, A, B, ALUOut and all registers = 0. FSM=IDLE, mem_req=mem_we=misalign=0, mem_be=0.
- Strobe at cycle n → mem_req high from n+1. mem_ready sampled at n+k (k≥1) → data captured at that edge, mem_req low at n+k+1. Minimum access = 2 cycles; wait states are unbounded.
- mem_ready while IDLE is ignored.
- Reset during WAIT drops mem_req next cycle, with no capture.
- misalign is exactly one cycle; no bus activity.

## Test plan
- Reset with PC_RESET=32'h0040_0000 → PC_Current=0x0040_0000, mem_req=0, regs read 0. Fetch with mem_ready after 3 wait cycles → IR=data2CPU, PC unchanged throughout busy.
- LB from addr 0x…03, data2CPU=0x80xx_xxxx → MDR=0xFFFF_FF80. LBU → 0x0000_0080. LHU at 0x…02, data 0xBEEF_xxxx → 0x0000_BEEF.
- SB at 0x…01, B=0x0000_00AB → mem_be=0010, data_out=0xABAB_ABAB, mem_we=1. SW at 0x…02 → misalign pulse, no mem_req.
- BNE: A=5, B=5, SUB → no PC write. A=5, B=6 → PC=ALUOut. Same operands with BranchNe=0 → opposite results.
- ADD 0x7FFF_FFFF+1 → overflow=1. SLT −1<1 → 1. SLTU → 0. SRA 0x8000_0000 by 4 → 0xF800_0000.
- JAL: RegDst=10, MemtoReg=10 → $31=PC_Current. A write to $0 reads back 0. NREGS=16: a write to $20 is dropped.
